multiplier_controller_tainttrack: RTL and testbench

Control FSM that sits directly upstream of the taint-tracked sequential multiplier datapath. It sequences the shift-add algorithm by driving the datapath's load, clear and shift strobes, and reads back the datapath's multiplier register to decide each add. Every control output carries a companion taint bit, so information flow from a tainted `start` or tainted multiplier bits into the datapath's control inputs stays visible.

---
 rtl/multiplier_controller_tainttrack_if.sv | 37 +++
 rtl/multiplier_controller_tainttrack.sv | 112 +++++++++++
 tb/tb_multiplier_controller_tainttrack.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_controller_tainttrack_if.sv
// Control/status bundle between the multiplier controller (master) and the
// taint-tracked shift-add datapath plus requester (slave).
interface multiplier_controller_tainttrack_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             start_t;
    logic [WIDTH-1:0] multiplierReg;
    logic [WIDTH-1:0] multiplierReg_t;
    logic             mrld;
    logic             mdld;
    logic             rsclear;
    logic             rsload;
    logic             rsshr;
    logic             mrld_t;
    logic             mdld_t;
    logic             rsclear_t;
    logic             rsload_t;
    logic             rsshr_t;
    logic             busy;
    logic             done;
    logic             done_t;

    modport master (
        input  start, start_t, multiplierReg, multiplierReg_t,
        output mrld, mdld, rsclear, rsload, rsshr,
        output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        output busy, done, done_t
    );

    modport slave (
        output start, start_t, multiplierReg, multiplierReg_t,
        input  mrld, mdld, rsclear, rsload, rsshr,
        input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
        input  busy, done, done_t
    );
endinterface

// File: rtl/multiplier_controller_tainttrack.sv
// Shift-add sequencing FSM for the taint-tracked multiplier datapath; every
// strobe carries a sticky per-operation taint collected from start and the scanned multiplier bits.
module multiplier_controller_tainttrack #(
    parameter int WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    multiplier_controller_tainttrack_if.master   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          ctl_t_reg, ctl_t_next;
    logic [IW-1:0] bit_idx;
    logic          taint;

    assign bit_idx = cnt_reg[IW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ctl_t_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ctl_t_reg <= ctl_t_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ctl_t_next = ctl_t_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = INIT;
                    ctl_t_next = bus.start_t;
                end
            end
            INIT: begin
                cnt_next   = '0;
                state_next = TEST;
            end
            TEST: begin
                // Taint from the scanned bit joins the flag whether or not it is set,
                // since it decides the ADD/SHIFT path either way.
                ctl_t_next = ctl_t_reg | bus.multiplierReg_t[bit_idx];
                state_next = bus.multiplierReg[bit_idx] ? ADD : SHIFT;
            end
            ADD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                cnt_next   = cnt_reg + 1'b1;
                state_next = (cnt_reg == CW'(WIDTH - 1)) ? DONE : TEST;
            end
            DONE: begin
                ctl_t_next = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                ctl_t_next = 1'b0;
            end
        endcase
    end

    // Moore decode: outputs depend on registered state only.
    assign taint = (state_reg != IDLE) && ctl_t_reg;

    always_comb begin
        bus.mrld    = 1'b0;
        bus.mdld    = 1'b0;
        bus.rsclear = 1'b0;
        bus.rsload  = 1'b0;
        bus.rsshr   = 1'b0;
        bus.done    = 1'b0;
        case (state_reg)
            INIT: begin
                bus.mrld    = 1'b1;
                bus.mdld    = 1'b1;
                bus.rsclear = 1'b1;
            end
            ADD:     bus.rsload = 1'b1;
            SHIFT:   bus.rsshr  = 1'b1;
            DONE:    bus.done   = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.mrld_t    = taint;
    assign bus.mdld_t    = taint;
    assign bus.rsclear_t = taint;
    assign bus.rsload_t  = taint;
    assign bus.rsshr_t   = taint;
    assign bus.done_t    = taint;
endmodule

// File: tb/tb_multiplier_controller_tainttrack.sv
// Directed bench: controller driving a small behavioural shift-add datapath.
module tb_multiplier_controller_tainttrack;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multiplier_controller_tainttrack_if #(.WIDTH(W)) bus ();

    multiplier_controller_tainttrack #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural datapath: shift overrides add, sum is 2W+1 bits.
    logic [W-1:0]   tb_mul, tb_md, tb_mrt;
    logic [W-1:0]   dp_mr, dp_mrt, dp_md;
    logic [2*W:0]   dp_sum;

    always_ff @(posedge clk) begin
        if (bus.mrld) begin
            dp_mr  <= tb_mul;
            dp_mrt <= tb_mrt;
        end
        if (bus.mdld) dp_md <= tb_md;
        if (bus.rsclear)     dp_sum <= '0;
        else if (bus.rsshr)  dp_sum <= dp_sum >> 1;
        else if (bus.rsload) dp_sum <= dp_sum + {1'b0, dp_md, {W{1'b0}}};
    end

    assign bus.multiplierReg   = dp_mr;
    assign bus.multiplierReg_t = dp_mrt;

    wire [5:0] stb_now = {bus.mrld, bus.mdld, bus.rsclear, bus.rsload, bus.rsshr, bus.done};
    wire [5:0] tnt_now = {bus.mrld_t, bus.mdld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t, bus.done_t};

    int compared = 0;
    int mismatched = 0;

    logic [5:0] stb_tr [0:63];
    logic [5:0] tnt_tr [0:63];
    int         tr_done, tr_adds;
    bit         tr_overlap;
    logic [7:0] tr_prod;
    logic       idle_busy;
    logic [5:0] idle_stb, idle_tnt;

    // Issues one start in IDLE and records the cycle trace; cycle n is the
    // state n edges after... cycle 1 follows the sampling edge directly.
    task automatic run_op(input logic [W-1:0] mul, input logic [W-1:0] md,
                          input logic [W-1:0] mrt, input logic st_t, input bit hold);
        tb_mul = mul; tb_md = md; tb_mrt = mrt;
        bus.start_t = st_t;
        bus.start   = 1'b1;
        tr_done = -1; tr_adds = 0; tr_overlap = 0; tr_prod = '0;
        @(posedge clk); #1;
        if (!hold) begin
            bus.start   = 1'b0;
            bus.start_t = 1'b0;
        end
        for (int n = 1; n < 40 && tr_done < 0; n++) begin
            stb_tr[n] = stb_now;
            tnt_tr[n] = tnt_now;
            if (bus.rsload) tr_adds++;
            if (bus.rsload && bus.rsshr) tr_overlap = 1;
            if (bus.done) begin
                tr_done = n;
                tr_prod = dp_sum[7:0];
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        idle_busy = bus.busy;
        idle_stb  = stb_now;
        idle_tnt  = tnt_now;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.start_t = 1'b0;
        tb_mul = '0; tb_md = '0; tb_mrt = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        compared++;
        if (stb_now !== 6'b0) begin mismatched++; $display("FAIL reset_strobes got=%b want=000000", stb_now); end
        compared++;
        if (tnt_now !== 6'b0) begin mismatched++; $display("FAIL reset_taints got=%b want=000000", tnt_now); end
        reset = 1'b0;
        @(posedge clk); #1;
        $display("test_reset: busy=%b strobes=%b taints=%b", bus.busy, stb_now, tnt_now);
    endtask

    task automatic test_basic();
        run_op(4'd11, 4'd13, 4'd0, 1'b0, 1'b0);
        $display("test_basic: 11x13 done@%0d adds=%0d product=%0d", tr_done, tr_adds, tr_prod);
        compared++;
        if (stb_tr[1] !== 6'b111000) begin mismatched++; $display("FAIL basic_init got=%b want=111000", stb_tr[1]); end
        compared++;
        if (tr_done !== 13) begin mismatched++; $display("FAIL basic_done_cycle got=%0d want=13", tr_done); end
        compared++;
        if (tr_adds !== 3) begin mismatched++; $display("FAIL basic_adds got=%0d want=3", tr_adds); end
        compared++;
        if (tr_prod !== 8'd143) begin mismatched++; $display("FAIL basic_product got=%0d want=143", tr_prod); end
        compared++;
        if (tr_overlap !== 1'b0) begin mismatched++; $display("FAIL basic_load_shift_overlap got=%b want=0", tr_overlap); end
        for (int n = 1; n <= 13; n++) begin
            compared++;
            if (tnt_tr[n] !== 6'b0) begin mismatched++; $display("FAIL basic_taint cycle=%0d got=%b want=000000", n, tnt_tr[n]); end
        end
        compared++;
        if (idle_busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle_busy got=%b want=0", idle_busy); end
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd15, 4'd0, 1'b0, 1'b0);
        $display("test_zero: 0x15 done@%0d adds=%0d product=%0d", tr_done, tr_adds, tr_prod);
        compared++;
        if (tr_done !== 10) begin mismatched++; $display("FAIL zero_done_cycle got=%0d want=10", tr_done); end
        compared++;
        if (tr_adds !== 0) begin mismatched++; $display("FAIL zero_adds got=%0d want=0", tr_adds); end
        compared++;
        if (tr_prod !== 8'd0) begin mismatched++; $display("FAIL zero_product got=%0d want=0", tr_prod); end
    endtask

    task automatic test_max();
        run_op(4'd15, 4'd15, 4'd0, 1'b0, 1'b0);
        $display("test_max: 15x15 done@%0d adds=%0d product=%0d", tr_done, tr_adds, tr_prod);
        compared++;
        if (tr_done !== 14) begin mismatched++; $display("FAIL max_done_cycle got=%0d want=14", tr_done); end
        compared++;
        if (tr_adds !== 4) begin mismatched++; $display("FAIL max_adds got=%0d want=4", tr_adds); end
        compared++;
        if (tr_prod !== 8'd225) begin mismatched++; $display("FAIL max_product got=%0d want=225", tr_prod); end
        compared++;
        if (tr_overlap !== 1'b0) begin mismatched++; $display("FAIL max_load_shift_overlap got=%b want=0", tr_overlap); end
    endtask

    // 5 = bits 0,2; bit-2 TEST is cycle 7, so taint shows from cycle 8 (ADD).
    task automatic test_mulbit_taint();
        logic [5:0] exp_t;
        run_op(4'd5, 4'd3, 4'b0100, 1'b0, 1'b0);
        $display("test_mulbit_taint: 5x3 done@%0d product=%0d idle_taint=%b", tr_done, tr_prod, idle_tnt);
        compared++;
        if (tr_done !== 12) begin mismatched++; $display("FAIL mbt_done_cycle got=%0d want=12", tr_done); end
        compared++;
        if (tr_prod !== 8'd15) begin mismatched++; $display("FAIL mbt_product got=%0d want=15", tr_prod); end
        for (int n = 1; n <= 12; n++) begin
            exp_t = (n >= 8) ? 6'b111111 : 6'b000000;
            compared++;
            if (tnt_tr[n] !== exp_t) begin mismatched++; $display("FAIL mbt_taint cycle=%0d got=%b want=%b", n, tnt_tr[n], exp_t); end
        end
        compared++;
        if (idle_tnt !== 6'b0) begin mismatched++; $display("FAIL mbt_idle_taint got=%b want=000000", idle_tnt); end
    endtask

    task automatic test_start_taint();
        run_op(4'd6, 4'd9, 4'd0, 1'b1, 1'b0);
        $display("test_start_taint: 6x9 done@%0d product=%0d idle_taint=%b", tr_done, tr_prod, idle_tnt);
        compared++;
        if (tr_done !== 12) begin mismatched++; $display("FAIL st_done_cycle got=%0d want=12", tr_done); end
        compared++;
        if (tr_prod !== 8'd54) begin mismatched++; $display("FAIL st_product got=%0d want=54", tr_prod); end
        for (int n = 1; n <= 12; n++) begin
            compared++;
            if (tnt_tr[n] !== 6'b111111) begin mismatched++; $display("FAIL st_taint cycle=%0d got=%b want=111111", n, tnt_tr[n]); end
        end
        compared++;
        if (idle_tnt !== 6'b0) begin mismatched++; $display("FAIL st_idle_taint got=%b want=000000", idle_tnt); end
    endtask

    task automatic test_reset_mid();
        int adds_seen;
        int n;
        bit got_done;
        tb_mul = 4'd11; tb_md = 4'd13; tb_mrt = '0;
        bus.start_t = 1'b0;
        bus.start   = 1'b1;
        adds_seen = 0;
        @(posedge clk); #1;
        for (n = 1; n < 30 && adds_seen < 2; n++) begin
            if (bus.rsload) adds_seen++;
            if (adds_seen < 2) begin @(posedge clk); #1; end
        end
        compared++;
        if (adds_seen !== 2) begin mismatched++; $display("FAIL rm_second_add_seen got=%0d want=2", adds_seen); end
        reset = 1'b1;
        @(posedge clk); #1;
        $display("test_reset_mid: after reset busy=%b strobes=%b taints=%b", bus.busy, stb_now, tnt_now);
        compared++;
        if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rm_busy got=%b want=0", bus.busy); end
        compared++;
        if (stb_now !== 6'b0) begin mismatched++; $display("FAIL rm_strobes got=%b want=000000", stb_now); end
        compared++;
        if (tnt_now !== 6'b0) begin mismatched++; $display("FAIL rm_taints got=%b want=000000", tnt_now); end
        reset = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (stb_now !== 6'b111000) begin mismatched++; $display("FAIL rm_reinit got=%b want=111000", stb_now); end
        bus.start = 1'b0;
        got_done = 0;
        for (int k = 0; k < 30 && !got_done; k++) begin
            @(posedge clk); #1;
            if (bus.done) got_done = 1;
        end
        $display("test_reset_mid: restart done=%b product=%0d", got_done, dp_sum[7:0]);
        compared++;
        if (got_done !== 1'b1) begin mismatched++; $display("FAIL rm_restart_done got=%b want=1", got_done); end
        compared++;
        if (dp_sum[7:0] !== 8'd143) begin mismatched++; $display("FAIL rm_product got=%0d want=143", dp_sum[7:0]); end
        @(posedge clk); #1;
    endtask

    // start held high across DONE: one IDLE cycle, then a fresh INIT.
    task automatic test_back_to_back();
        bit got_done;
        run_op(4'd3, 4'd7, 4'd0, 1'b0, 1'b1);
        $display("test_back_to_back: 3x7 done@%0d product=%0d idle_busy=%b", tr_done, tr_prod, idle_busy);
        compared++;
        if (tr_done !== 12) begin mismatched++; $display("FAIL b2b_done_cycle got=%0d want=12", tr_done); end
        compared++;
        if (tr_prod !== 8'd21) begin mismatched++; $display("FAIL b2b_product got=%0d want=21", tr_prod); end
        compared++;
        if (idle_busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle_after_done got=%b want=0", idle_busy); end
        @(posedge clk); #1;
        compared++;
        if (stb_now !== 6'b111000) begin mismatched++; $display("FAIL b2b_second_init got=%b want=111000", stb_now); end
        bus.start = 1'b0;
        got_done = 0;
        for (int k = 0; k < 30 && !got_done; k++) begin
            @(posedge clk); #1;
            if (bus.done) got_done = 1;
        end
        $display("test_back_to_back: second op done=%b product=%0d", got_done, dp_sum[7:0]);
        compared++;
        if (got_done !== 1'b1) begin mismatched++; $display("FAIL b2b_second_done got=%b want=1", got_done); end
        compared++;
        if (dp_sum[7:0] !== 8'd21) begin mismatched++; $display("FAIL b2b_second_product got=%0d want=21", dp_sum[7:0]); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.start_t = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_mulbit_taint();
        test_start_taint();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
